// File: rtl/block_loader_if.sv
// rtl/block_loader_if.sv - word stream handshake into the block loader
interface block_loader_if #(
  parameter int DATAW = 10
);
  logic [DATAW-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             key_hold;

  modport master (output in_data, output in_valid, output key_hold, input in_ready);
  modport slave  (input in_data, input in_valid, input key_hold, output in_ready);
endinterface

// File: rtl/block_loader.sv
// rtl/block_loader.sv - assembles key/data blocks from a word stream, double-buffered
module block_loader #(
  parameter int DATAW = 10
) (
  input  logic               clk,
  input  logic               rst,
  block_loader_if.slave      strm,
  input  logic               lfsrset,
  output logic [4*DATAW-1:0] Key,
  output logic [2*DATAW-1:0] Data,
  output logic               income,
  output logic               underrun
);

  logic [2:0]         wcnt;
  logic               key_loaded;
  logic               lfsrset_q;
  logic               sh_full;
  logic [4*DATAW-1:0] sh_key;
  logic [2*DATAW-1:0] sh_data;

  logic accept;
  logic consume;
  logic promote;
  logic hold_frame;

  assign strm.in_ready = ~sh_full;
  assign accept        = strm.in_valid & ~sh_full;
  assign consume       = lfsrset_q & ~lfsrset;
  assign promote       = sh_full & (~income | consume);
  // A key_hold request only counts once a key has actually been loaded.
  assign hold_frame    = (wcnt == 3'd0) & strm.key_hold & key_loaded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt       <= 3'd0;
      key_loaded <= 1'b0;
      lfsrset_q  <= 1'b0;
      sh_full    <= 1'b0;
      sh_key     <= '0;
      sh_data    <= '0;
      Key        <= '0;
      Data       <= '0;
      income     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      lfsrset_q <= lfsrset;

      // accept needs an empty shadow and promote a full one, so they never collide
      if (accept) begin
        if (hold_frame) begin
          sh_data[0 +: DATAW] <= strm.in_data;
          wcnt                <= 3'd5;
        end else if (wcnt < 3'd4) begin
          sh_key[int'(wcnt[1:0])*DATAW +: DATAW] <= strm.in_data;
          wcnt                                   <= wcnt + 3'd1;
        end else if (wcnt == 3'd4) begin
          sh_data[0 +: DATAW] <= strm.in_data;
          wcnt                <= 3'd5;
        end else begin
          sh_data[DATAW +: DATAW] <= strm.in_data;
          wcnt                    <= 3'd0;
          sh_full                 <= 1'b1;
          key_loaded              <= 1'b1;
        end
      end

      if (promote) begin
        Key     <= sh_key;
        Data    <= sh_data;
        income  <= 1'b1;
        sh_full <= 1'b0;
      end else if (consume) begin
        income <= 1'b0;
      end

      if (consume & ~income) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_block_loader.sv
// tb/tb_block_loader.sv - self-checking bench for block_loader
module tb_block_loader;
  localparam int DATAW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lfsrset = 1'b0;
  logic [4*DATAW-1:0] Key;
  logic [2*DATAW-1:0] Data;
  logic income;
  logic underrun;

  int checks = 0;
  int failures = 0;

  block_loader_if #(.DATAW(DATAW)) bus ();

  block_loader #(.DATAW(DATAW)) dut (
    .clk(clk), .rst(rst), .strm(bus), .lfsrset(lfsrset),
    .Key(Key), .Data(Data), .income(income), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Reference model: words are collected in a queue until a frame's worth has arrived.
  logic [DATAW-1:0]   m_q[$];
  bit                 m_hold;
  bit                 m_sh_full, m_income, m_underrun, m_key_loaded, m_lq;
  logic [4*DATAW-1:0] m_sh_key, m_key;
  logic [2*DATAW-1:0] m_sh_data, m_data;

  function automatic void model_reset();
    m_q.delete();
    m_hold = 0; m_sh_full = 0; m_income = 0; m_underrun = 0; m_key_loaded = 0; m_lq = 0;
    m_sh_key = '0; m_key = '0; m_sh_data = '0; m_data = '0;
  endfunction

  function automatic void model_step(bit v, logic [DATAW-1:0] d, bit h, bit l);
    bit acc, cons, prom, old_income;
    acc = v && !m_sh_full;
    cons = m_lq && !l;
    prom = m_sh_full && (!m_income || cons);
    old_income = m_income;
    if (acc) begin
      if (m_q.size() == 0) m_hold = h && m_key_loaded;
      m_q.push_back(d);
      if (m_hold && m_q.size() == 2) begin
        m_sh_data = {m_q[1], m_q[0]};
        m_sh_full = 1; m_key_loaded = 1; m_q.delete();
      end else if (!m_hold && m_q.size() == 6) begin
        m_sh_key = {m_q[3], m_q[2], m_q[1], m_q[0]};
        m_sh_data = {m_q[5], m_q[4]};
        m_sh_full = 1; m_key_loaded = 1; m_q.delete();
      end
    end
    if (prom) begin
      m_key = m_sh_key; m_data = m_sh_data; m_income = 1; m_sh_full = 0;
    end else if (cons) begin
      m_income = 0;
    end
    if (cons && !old_income) m_underrun = 1;
    m_lq = l;
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(bus.in_valid, bus.in_data, bus.key_hold, lfsrset);
    #1;
  endtask

  task automatic drv(bit v, logic [DATAW-1:0] d, bit h, bit l);
    bus.in_valid = v; bus.in_data = d; bus.key_hold = h; lfsrset = l;
    tick();
  endtask

  task automatic do_reset();
    bus.in_valid = 0; bus.in_data = '0; bus.key_hold = 0; lfsrset = 0;
    rst = 1;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic send_frame(logic [DATAW-1:0] base);
    for (int i = 0; i < 6; i++) drv(1, base + DATAW'(i), 0, 0);
  endtask

  task automatic check_model(string tag);
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(!m_sh_full));
    chk({tag, ".income"}, 64'(income), 64'(m_income));
    chk({tag, ".underrun"}, 64'(underrun), 64'(m_underrun));
    chk({tag, ".Key"}, 64'(Key), 64'(m_key));
    chk({tag, ".Data"}, 64'(Data), 64'(m_data));
  endtask

  typedef struct {
    bit v; logic [DATAW-1:0] d; bit h; bit l;
    bit e_rdy; bit e_inc; logic [4*DATAW-1:0] e_key; logic [2*DATAW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(bit v, logic [DATAW-1:0] d, bit l, bit rdy, bit inc,
                      logic [4*DATAW-1:0] k, logic [2*DATAW-1:0] dt);
    vec_t e;
    e.v = v; e.d = d; e.h = 0; e.l = l; e.e_rdy = rdy; e.e_inc = inc; e.e_key = k; e.e_data = dt;
    tbl.push_back(e);
  endtask

  initial begin
    logic [4*DATAW-1:0] k1, k2;
    logic [2*DATAW-1:0] d1, d2;
    k1 = {10'h004, 10'h003, 10'h002, 10'h001}; d1 = {10'h006, 10'h005};
    k2 = {10'h014, 10'h013, 10'h012, 10'h011}; d2 = {10'h016, 10'h015};

    for (int i = 1; i <= 5; i++) addv(1, DATAW'(i), 0, 1, 0, '0, '0);
    addv(1, 10'h006, 0, 0, 0, '0, '0);
    addv(0, 10'h000, 0, 1, 1, k1, d1);
    for (int i = 1; i <= 5; i++) addv(1, DATAW'(10'h010 + i), 0, 1, 1, k1, d1);
    addv(1, 10'h016, 0, 0, 1, k1, d1);
    addv(1, 10'h3FF, 0, 0, 1, k1, d1);
    addv(0, 10'h000, 1, 0, 1, k1, d1);
    addv(0, 10'h000, 0, 1, 1, k2, d2);
    addv(0, 10'h000, 0, 1, 1, k2, d2);

    do_reset();
    chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset.income", 64'(income), 64'd0);
    chk("reset.underrun", 64'(underrun), 64'd0);
    chk("reset.Key", 64'(Key), 64'd0);
    chk("reset.Data", 64'(Data), 64'd0);

    // Tests 1 and 2: single frame, then a second frame that waits in the shadow
    foreach (tbl[i]) begin
      drv(tbl[i].v, tbl[i].d, tbl[i].h, tbl[i].l);
      chk($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.income", i), 64'(income), 64'(tbl[i].e_inc));
      chk($sformatf("vec%0d.Key", i), 64'(Key), 64'(tbl[i].e_key));
      chk($sformatf("vec%0d.Data", i), 64'(Data), 64'(tbl[i].e_data));
    end

    // Test 3: data-only frame reuses the loaded key
    drv(1, 10'h0AA, 1, 0);
    drv(1, 10'h0BB, 0, 0);
    drv(0, 10'h000, 0, 0);
    chk("hold.stall", 64'(bus.in_ready), 64'd0);
    chk("hold.data_before", 64'(Data), 64'(d2));
    drv(0, 10'h000, 0, 1);
    drv(0, 10'h000, 0, 0);
    chk("hold.Key", 64'(Key), 64'(k2));
    chk("hold.Data", 64'(Data), 64'({10'h0BB, 10'h0AA}));
    chk("hold.income", 64'(income), 64'd1);

    // Test 4: key_hold ignored before any key is loaded
    do_reset();
    drv(1, 10'h021, 1, 0);
    drv(1, 10'h022, 0, 0);
    drv(0, 10'h000, 0, 0);
    drv(0, 10'h000, 0, 0);
    chk("nokey.in_ready", 64'(bus.in_ready), 64'd1);
    chk("nokey.income", 64'(income), 64'd0);
    for (int i = 3; i <= 6; i++) drv(1, DATAW'(10'h020 + i), 0, 0);
    drv(0, 10'h000, 0, 0);
    chk("nokey.Key", 64'(Key), 64'({10'h024, 10'h023, 10'h022, 10'h021}));
    chk("nokey.Data", 64'(Data), 64'({10'h026, 10'h025}));

    // Test 5: consume with nothing active raises underrun
    do_reset();
    send_frame(10'h031);
    drv(0, 10'h000, 0, 0);
    chk("under.income_up", 64'(income), 64'd1);
    drv(0, 10'h000, 0, 1);
    drv(0, 10'h000, 0, 0);
    chk("under.income_down", 64'(income), 64'd0);
    chk("under.not_yet", 64'(underrun), 64'd0);
    chk("under.key_held", 64'(Key), 64'({10'h034, 10'h033, 10'h032, 10'h031}));
    drv(0, 10'h000, 0, 1);
    drv(0, 10'h000, 0, 0);
    chk("under.set", 64'(underrun), 64'd1);
    drv(0, 10'h000, 0, 0);
    chk("under.sticky", 64'(underrun), 64'd1);

    // Test 6: reset mid-frame, then consume coinciding with last-word accept
    do_reset();
    drv(1, 10'h101, 0, 0);
    drv(1, 10'h102, 0, 0);
    drv(1, 10'h103, 0, 0);
    do_reset();
    chk("midrst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst.income", 64'(income), 64'd0);
    chk("midrst.Key", 64'(Key), 64'd0);
    send_frame(10'h041);
    drv(0, 10'h000, 0, 0);
    chk("midrst.newKey", 64'(Key), 64'({10'h044, 10'h043, 10'h042, 10'h041}));
    chk("midrst.newData", 64'(Data), 64'({10'h046, 10'h045}));
    for (int i = 1; i <= 4; i++) drv(1, DATAW'(10'h050 + i), 0, 0);
    drv(1, 10'h055, 0, 1);
    drv(1, 10'h056, 0, 0);
    chk("simul.income", 64'(income), 64'd0);
    chk("simul.in_ready", 64'(bus.in_ready), 64'd0);
    drv(0, 10'h000, 0, 0);
    chk("simul.promote", 64'(income), 64'd1);
    chk("simul.Key", 64'(Key), 64'({10'h054, 10'h053, 10'h052, 10'h051}));
    chk("simul.Data", 64'(Data), 64'({10'h056, 10'h055}));

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drv(($urandom % 4) != 0, DATAW'($urandom), ($urandom % 3) == 0, ($urandom % 3) == 0);
      check_model($sformatf("rnd%0d", c));
      if (failures > 20) break;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
